alu_mc: RTL

- Parametrised, handshaked successor to the team's combinational MIPS-style ALU.
- Keeps the same 6-bit function encoding and status flags.
- Generalises datapath width and registers all results.
- Adds iterative multi-cycle MULT/MULTU/DIV/DIVU that produce a HI/LO pair; sits between the decode/issue stage and writeback.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_muldiv_iter.sv | 91 +++++++++
 rtl/alu_mc.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked multi-cycle ALU: function codes,
// controller states and opcode classification.
package alu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'b100000;
  localparam logic [5:0] ALU_ADDU  = 6'b100001;
  localparam logic [5:0] ALU_SUB   = 6'b100010;
  localparam logic [5:0] ALU_SUBU  = 6'b100011;
  localparam logic [5:0] ALU_AND   = 6'b100100;
  localparam logic [5:0] ALU_OR    = 6'b100101;
  localparam logic [5:0] ALU_XOR   = 6'b100110;
  localparam logic [5:0] ALU_NOR   = 6'b100111;
  localparam logic [5:0] ALU_SLT   = 6'b101010;
  localparam logic [5:0] ALU_SLTU  = 6'b101011;
  localparam logic [5:0] ALU_SLL   = 6'b000000;
  localparam logic [5:0] ALU_SRL   = 6'b000010;
  localparam logic [5:0] ALU_SRA   = 6'b000011;
  localparam logic [5:0] ALU_SLLV  = 6'b000100;
  localparam logic [5:0] ALU_SRLV  = 6'b000110;
  localparam logic [5:0] ALU_SRAV  = 6'b000111;
  localparam logic [5:0] ALU_LUI   = 6'b001111;
  localparam logic [5:0] ALU_MULT  = 6'b011000;
  localparam logic [5:0] ALU_MULTU = 6'b011001;
  localparam logic [5:0] ALU_DIV   = 6'b011010;
  localparam logic [5:0] ALU_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} alu_state_e;

  // MULT/MULTU/DIV/DIVU share the 0110xx prefix; bit0 = unsigned, bit1 = divide.
  function automatic logic is_multicycle(input logic [5:0] op);
    return op[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with sign fix-up applied combinationally to the finished result.
module alu_muldiv_iter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         signed_i,
  input  logic         div_sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         done_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o,
  output logic         ovf_o
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]   hi_q, lo_q, dvs_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q, div_q, neg_lo_q, neg_hi_q, div0_q, ovf_q;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] init_nxt, run_nxt, prod_fx;
  logic [W-1:0]   quo_fx, rem_fx;

  // One iteration: mul adds the multiplicand when lo[0] is set and shifts the
  // {carry,hi,lo} pair right; div shifts one dividend bit into the remainder.
  function automatic logic [2*W-1:0] step(input logic dv, input logic [W-1:0] h,
                                          input logic [W-1:0] l, input logic [W-1:0] d);
    logic [W:0] s;
    logic [W:0] df;
    if (dv) begin
      s  = {h, l[W-1]};
      df = s - {1'b0, d};
      if (!df[W]) return {df[W-1:0], l[W-2:0], 1'b1};
      return {s[W-1:0], l[W-2:0], 1'b0};
    end
    s = {1'b0, h} + (l[0] ? {1'b0, d} : '0);
    return {s, l[W-1:1]};
  endfunction

  always_comb begin
    a_mag    = (signed_i && a_i[W-1]) ? -a_i : a_i;
    b_mag    = (signed_i && b_i[W-1]) ? -b_i : b_i;
    // The first iteration runs on the accept edge so W iterations end one cycle before FIN.
    init_nxt = step(div_sel_i, '0, div_sel_i ? a_mag : b_mag, div_sel_i ? b_mag : a_mag);
    run_nxt  = step(div_q, hi_q, lo_q, dvs_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (start_i) begin
      {hi_q, lo_q} <= init_nxt;
      dvs_q    <= div_sel_i ? b_mag : a_mag;
      cnt_q    <= CW'(1);
      busy_q   <= 1'b1;
      div_q    <= div_sel_i;
      neg_lo_q <= signed_i && (a_i[W-1] ^ b_i[W-1]);
      neg_hi_q <= signed_i && a_i[W-1];
      div0_q   <= div_sel_i && (b_i == '0);
      ovf_q    <= div_sel_i && signed_i && (a_i == {1'b1, {(W-1){1'b0}}}) && (b_i == '1);
    end else if (busy_q) begin
      {hi_q, lo_q} <= run_nxt;
      cnt_q    <= cnt_q + CW'(1);
      if (cnt_q == CW'(W-1)) busy_q <= 1'b0;
    end
  end

  always_comb begin
    prod_fx = neg_lo_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fx  = div0_q ? '1 : (neg_lo_q ? -lo_q : lo_q);
    rem_fx  = neg_hi_q ? -hi_q : hi_q;
    hi_o    = div_q ? rem_fx : prod_fx[2*W-1:W];
    lo_o    = div_q ? quo_fx : prod_fx[W-1:0];
    ovf_o   = ovf_q;
    done_o  = busy_q && (cnt_q == CW'(W-1));
  end

endmodule

// File: rtl/alu_mc.sv
// Handshaked MIPS-style ALU: single-cycle datapath with registered results,
// plus an iterative engine for MULT/MULTU/DIV/DIVU producing a HI/LO pair.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned W   = 32,
  parameter int unsigned SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [5:0]   aluc,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r,
  output logic [W-1:0] hi,
  output logic         zero,
  output logic         carry,
  output logic         negative,
  output logic         overflow,
  output logic         flag,
  output logic         illegal
);

  alu_state_e   state_q;
  logic         out_valid_q, zero_q, carry_q, neg_q, ovf_q, flag_q, illegal_q;
  logic [W-1:0] r_q, hi_q;

  logic         accept, md_start, md_done, md_ovf;
  logic [W-1:0] md_hi, md_lo;

  logic [W:0]     sum, dif;
  logic [SHW-1:0] shamt;
  logic [W-1:0]   sc_r;
  logic           sc_c, sc_o, sc_f, sc_il;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_multicycle(aluc);

  alu_muldiv_iter #(.W(W)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (md_start),
    .signed_i  (!aluc[0]),
    .div_sel_i (aluc[1]),
    .a_i       (a),
    .b_i       (b),
    .done_o    (md_done),
    .hi_o      (md_hi),
    .lo_o      (md_lo),
    .ovf_o     (md_ovf)
  );

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    shamt = a[SHW-1:0];
    sc_r  = '0;
    sc_c  = 1'b0;
    sc_o  = 1'b0;
    sc_f  = 1'b0;
    sc_il = 1'b0;
    case (aluc)
      ALU_ADD: begin
        sc_r = sum[W-1:0];
        sc_c = sum[W];
        sc_o = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_ADDU: begin
        sc_r = sum[W-1:0];
        sc_c = sum[W];
      end
      ALU_SUB: begin
        sc_r = dif[W-1:0];
        sc_c = dif[W];
        sc_o = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
      end
      ALU_SUBU: begin
        sc_r = dif[W-1:0];
        sc_c = dif[W];
      end
      ALU_AND: sc_r = a & b;
      ALU_OR:  sc_r = a | b;
      ALU_XOR: sc_r = a ^ b;
      ALU_NOR: sc_r = ~(a | b);
      ALU_SLT: begin
        sc_f = $signed(a) < $signed(b);
        sc_r = {{(W-1){1'b0}}, sc_f};
      end
      ALU_SLTU: begin
        sc_f = a < b;
        sc_r = {{(W-1){1'b0}}, sc_f};
      end
      ALU_SLL, ALU_SLLV: sc_r = b << shamt;
      ALU_SRL, ALU_SRLV: sc_r = b >> shamt;
      ALU_SRA, ALU_SRAV: sc_r = $signed(b) >>> shamt;
      ALU_LUI:           sc_r = b << (W/2);
      default:           sc_il = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      flag_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_multicycle(aluc)) begin
              state_q <= aluc[1] ? DIV : MUL;
            end else begin
              r_q         <= sc_r;
              hi_q        <= '0;
              zero_q      <= !sc_il && (sc_r == '0);
              carry_q     <= sc_c;
              neg_q       <= sc_r[W-1];
              ovf_q       <= sc_o;
              flag_q      <= sc_f;
              illegal_q   <= sc_il;
              out_valid_q <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          if (md_done) state_q <= FIN;
        end
        FIN: begin
          r_q         <= md_lo;
          hi_q        <= md_hi;
          zero_q      <= (md_lo == '0);
          carry_q     <= 1'b0;
          neg_q       <= md_lo[W-1];
          ovf_q       <= md_ovf;
          flag_q      <= 1'b0;
          illegal_q   <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign flag      = flag_q;
  assign illegal   = illegal_q;

endmodule
